shift_sequencer: RTL

Multi-cycle controller for shift instructions (SLL/SRL/SRA/ROTR and their variable forms). It selects the effective 5-bit shift amount: the instruction shamt field, or rs[4:0] for variable shifts. It drives the zero-extended 32-bit shift amount to the datapath. It then sequences an iterative shift of up to STEP bit positions per cycle, with a start/done handshake to the main control FSM. It sits beside the ALU and replaces a single-cycle barrel shifter on timing-critical builds.

---
 rtl/shift_ctrl_pkg.sv | 17 +
 rtl/shift_step.sv | 28 ++
 rtl/shift_sequencer.sv | 116 +++++++++++
 3 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the iterative shift controller: op codes, FSM states, word width.
package shift_ctrl_pkg;

    localparam int WORD = 32;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves acc by k (0..STEP) positions for one iteration.
module shift_step
    import shift_ctrl_pkg::*;
#(
    parameter int KW = 3
) (
    input  logic [WORD-1:0] acc,
    input  logic [1:0]      op,
    input  logic [KW-1:0]   k,
    output logic [WORD-1:0] acc_next
);

    logic [5:0] amt;
    assign amt = 6'(k);

    always_comb begin
        acc_next = acc;
        case (op)
            OP_SLL:  acc_next = acc << amt;
            OP_SRL:  acc_next = acc >> amt;
            OP_SRA:  acc_next = $signed(acc) >>> amt;
            // a shift by WORD yields zero, so k=0 degenerates cleanly to acc
            OP_ROTR: acc_next = (acc >> amt) | (acc << (6'(WORD) - amt));
            default: acc_next = acc;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: latches operands at start, shifts up to STEP bits per
// cycle, then pulses done for one cycle with result already valid.
module shift_sequencer
    import shift_ctrl_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic            use_reg,
    input  logic [4:0]      shamt,
    input  logic [31:0]     rs_val,
    input  logic [31:0]     data,
    output logic            busy,
    output logic            done,
    output logic [31:0]     result,
    output logic [31:0]     shamt_ext
);

    localparam int KW = $clog2(STEP) + 1;

    state_t          state_reg, state_next;
    logic [WORD-1:0] acc_reg, acc_next;
    logic [1:0]      opr_reg, opr_next;
    logic [4:0]      rem_reg, rem_next;
    logic [WORD-1:0] result_reg, result_next;
    logic [WORD-1:0] shamt_ext_reg, shamt_ext_next;

    logic [4:0]      n_sel;
    logic [KW-1:0]   k;
    logic [WORD-1:0] stepped;
    logic            unused_rs;

    assign n_sel     = use_reg ? rs_val[4:0] : shamt;
    assign unused_rs = ^rs_val[31:5];

    always_comb begin
        k = KW'(rem_reg);
        if (rem_reg > 5'(STEP)) begin
            k = KW'(STEP);
        end
    end

    shift_step #(.KW(KW)) u_step (
        .acc      (acc_reg),
        .op       (opr_reg),
        .k        (k),
        .acc_next (stepped)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            opr_reg       <= OP_SLL;
            rem_reg       <= '0;
            result_reg    <= '0;
            shamt_ext_reg <= '0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            opr_reg       <= opr_next;
            rem_reg       <= rem_next;
            result_reg    <= result_next;
            shamt_ext_reg <= shamt_ext_next;
        end
    end

    // result is loaded on entry to DONE so it is valid during the done pulse
    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        opr_next       = opr_reg;
        rem_next       = rem_reg;
        result_next    = result_reg;
        shamt_ext_next = shamt_ext_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    acc_next       = data;
                    opr_next       = op;
                    rem_next       = n_sel;
                    shamt_ext_next = {27'b0, n_sel};
                    if (n_sel == 5'd0) begin
                        state_next  = DONE;
                        result_next = data;
                    end else begin
                        state_next  = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_next = stepped;
                rem_next = rem_reg - 5'(k);
                if (rem_next == 5'd0) begin
                    state_next  = DONE;
                    result_next = stepped;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign result    = result_reg;
    assign shamt_ext = shamt_ext_reg;

endmodule
